// File: rtl/pattern_pkg.sv
// Shared types and default pattern constants for the pattern transmitter, detector and bench.
package pattern_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    localparam int                    PAT_W_DEF   = 4;
    localparam logic [PAT_W_DEF-1:0]  PATTERN_DEF = 4'b1011;
    localparam int                    REP_W       = 8;

endpackage

// File: rtl/pattern_shreg.sv
// PAT_W-bit load/shift register, MSB out; load wins over shift.
module pattern_shreg #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         shift,
    input  logic [W-1:0] load_val,
    output logic         msb
);

    logic [W-1:0] sh_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh_q <= '0;
        end else if (load) begin
            sh_q <= load_val;
        end else if (shift) begin
            sh_q <= {sh_q[W-2:0], 1'b0};
        end
    end

    assign msb = sh_q[W-1];

endmodule

// File: rtl/pattern_tx.sv
// Bit-serial pattern burst transmitter; start sampled at edge N gives first valid bit after edge N+1.
// No backpressure: the stream is contiguous from first bit to last, then a one-cycle done pulse.
module pattern_tx
    import pattern_pkg::*;
#(
    parameter int               PAT_W   = PAT_W_DEF,
    parameter logic [PAT_W-1:0] PATTERN = PATTERN_DEF,
    parameter int               GAP_W   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [REP_W-1:0] rep_cnt,
    input  logic [GAP_W-1:0] gap,
    output logic             d_out,
    output logic             valid_out,
    output logic             busy,
    output logic             done,
    output logic [REP_W-1:0] tx_count
);

    localparam int               BIT_W    = (PAT_W > 1) ? $clog2(PAT_W) : 1;
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(PAT_W - 1);

    state_e             state_q;
    logic [BIT_W-1:0]   bit_cnt_q;
    logic [BIT_W-1:0]   bit_cnt_d;
    logic [GAP_W-1:0]   gap_cnt_q;
    logic [GAP_W-1:0]   gap_q;
    logic [REP_W-1:0]   rep_q;
    logic [REP_W-1:0]   tx_count_q;
    logic [REP_W-1:0]   tx_count_d;
    logic               d_out_q;
    logic               valid_q;
    logic               busy_q;
    logic               done_q;

    logic               bit_last;
    logic               last_rep;
    logic               gap_last;
    logic               start_ok;
    logic               sh_load;
    logic               sh_shift;
    logic               sh_msb;

    assign bit_last   = (bit_cnt_q == BIT_LAST);
    assign bit_cnt_d  = bit_last ? '0 : bit_cnt_q + 1'b1;
    assign tx_count_d = tx_count_q + 1'b1;
    assign last_rep   = (tx_count_d == rep_q);
    assign gap_last   = (gap_cnt_q == gap_q - 1'b1);
    assign start_ok   = start && (rep_cnt != '0);

    // The pattern is reloaded on every retiring bit, so it is ready whether
    // the next state is SEND (back-to-back) or GAP; a reload before DONE is harmless.
    assign sh_load  = ((state_q == ST_IDLE) && start_ok) ||
                      ((state_q == ST_SEND) && bit_last);
    assign sh_shift = (state_q == ST_SEND);

    pattern_shreg #(
        .W (PAT_W)
    ) u_shreg (
        .clk      (clk),
        .rst      (rst),
        .load     (sh_load),
        .shift    (sh_shift),
        .load_val (PATTERN),
        .msb      (sh_msb)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            bit_cnt_q  <= '0;
            gap_cnt_q  <= '0;
            gap_q      <= '0;
            rep_q      <= '0;
            tx_count_q <= '0;
            d_out_q    <= 1'b0;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    d_out_q <= 1'b0;
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    if (start) begin
                        tx_count_q <= '0;
                        if (start_ok) begin
                            rep_q     <= rep_cnt;
                            gap_q     <= gap;
                            bit_cnt_q <= '0;
                            state_q   <= ST_SEND;
                        end else begin
                            state_q   <= ST_DONE;
                        end
                    end
                end

                ST_SEND: begin
                    d_out_q   <= sh_msb;
                    valid_q   <= 1'b1;
                    busy_q    <= 1'b1;
                    done_q    <= 1'b0;
                    bit_cnt_q <= bit_cnt_d;
                    if (bit_last) begin
                        tx_count_q <= tx_count_d;
                        if (last_rep) begin
                            state_q <= ST_DONE;
                        end else if (gap_q != '0) begin
                            gap_cnt_q <= '0;
                            state_q   <= ST_GAP;
                        end
                    end
                end

                ST_GAP: begin
                    d_out_q   <= 1'b0;
                    valid_q   <= 1'b1;
                    busy_q    <= 1'b1;
                    done_q    <= 1'b0;
                    gap_cnt_q <= gap_cnt_q + 1'b1;
                    if (gap_last) begin
                        state_q <= ST_SEND;
                    end
                end

                ST_DONE: begin
                    d_out_q <= 1'b0;
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= ST_IDLE;
                end

                default: begin
                    d_out_q <= 1'b0;
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign d_out     = d_out_q;
    assign valid_out = valid_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign tx_count  = tx_count_q;

endmodule

// File: tb/tb_pattern_tx.sv
// Scoreboard bench for pattern_tx: expected bits queued at start, popped per valid cycle.
module tb_pattern_tx;
    import pattern_pkg::*;

    localparam int BUDGET = 6000;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] rep_cnt;
    logic [3:0] gap;
    logic       d_out;
    logic       valid_out;
    logic       busy;
    logic       done;
    logic [7:0] tx_count;

    int vectors;
    int miscompares;
    bit exp_q[$];

    pattern_tx #(
        .PAT_W   (PAT_W_DEF),
        .PATTERN (PATTERN_DEF),
        .GAP_W   (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .rep_cnt   (rep_cnt),
        .gap       (gap),
        .d_out     (d_out),
        .valid_out (valid_out),
        .busy      (busy),
        .done      (done),
        .tx_count  (tx_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Runs one burst; c=0 is the negedge right after the edge that samples start.
    task automatic run_burst(input int rep, input int gp, input bit spam,
                             output int nvalid, output int ndone, output int first_at,
                             output int done_at, output int ndet, output int tx_at_done);
        logic [PAT_W_DEF-1:0] win;
        logic [PAT_W_DEF-1:0] pat;
        int  c;
        int  last_v;
        int  after;
        bit  exp_b;
        bit  seen_done;
        pat = PATTERN_DEF;
        for (int r = 0; r < rep; r++) begin
            for (int b = PAT_W_DEF - 1; b >= 0; b--) exp_q.push_back(pat[b]);
            if (r < rep - 1)
                for (int g = 0; g < gp; g++) exp_q.push_back(1'b0);
        end
        nvalid = 0; ndone = 0; first_at = -1; done_at = -1; ndet = 0; tx_at_done = -1;
        win = '0; last_v = 0; after = 0; seen_done = 0; c = 0;

        @(posedge clk); #1;
        start = 1'b1; rep_cnt = rep[7:0]; gap = gp[3:0];
        @(posedge clk); #1;
        if (!spam) start = 1'b0;
        rep_cnt = 8'($urandom); gap = 4'($urandom);

        while (c < BUDGET && after < 4) begin
            @(negedge clk);
            if (spam) begin
                rep_cnt = 8'($urandom); gap = 4'($urandom);
            end
            if (valid_out) begin
                nvalid++;
                if (first_at < 0) first_at = c;
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL d_out_extra: valid bit %0d at cycle %0d, none expected", d_out, c);
                end else begin
                    exp_b = exp_q.pop_front();
                    if (d_out !== exp_b) begin
                        miscompares++;
                        $display("FAIL d_out: cycle %0d got %0b expected %0b", c, d_out, exp_b);
                    end
                end
                vectors++;
                if (nvalid > 1 && last_v != c - 1) begin
                    miscompares++;
                    $display("FAIL contiguity: valid at cycle %0d, previous at %0d", c, last_v);
                end
                last_v = c;
                vectors++;
                if (busy !== 1'b1) begin
                    miscompares++;
                    $display("FAIL busy_during_burst: cycle %0d got %0b expected 1", c, busy);
                end
                win = {win[PAT_W_DEF-2:0], d_out};
                if (nvalid >= PAT_W_DEF && win == pat) ndet++;
            end
            if (done) begin
                ndone++;
                vectors++;
                if (busy !== 1'b0 || valid_out !== 1'b0) begin
                    miscompares++;
                    $display("FAIL done_cycle: busy=%0b valid=%0b expected 0/0", busy, valid_out);
                end
                if (!seen_done) begin
                    done_at    = c;
                    tx_at_done = int'(tx_count);
                end
                seen_done = 1'b1;
                start     = 1'b0;
            end
            if (seen_done) after++;
            c++;
        end
        start = 1'b0;
        vectors++;
        if (!seen_done) begin
            miscompares++;
            $display("FAIL timeout: no done within %0d cycles", BUDGET);
        end
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL leftover_bits: %0d expected bits never sent, required 0", exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic test_reset();
        @(negedge clk);
        vectors++;
        if ({d_out, valid_out, busy, done} !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_flags: got d/v/b/d=%b expected 0000", {d_out, valid_out, busy, done});
        end
        vectors++;
        if (tx_count !== 8'd0) begin
            miscompares++;
            $display("FAIL reset_tx_count: got %0d expected 0", tx_count);
        end
        rst = 1'b0;
    endtask

    task automatic test_gap();
        int nv, nd, fa, da, det, tx;
        run_burst(3, 2, 1'b0, nv, nd, fa, da, det, tx);
        vectors++; if (nv != 16)  begin miscompares++; $display("FAIL gap_valid_cycles: got %0d expected 16", nv); end
        vectors++; if (fa != 1)   begin miscompares++; $display("FAIL gap_first_latency: got %0d expected 1", fa); end
        vectors++; if (da != 17)  begin miscompares++; $display("FAIL gap_done_cycle: got %0d expected 17", da); end
        vectors++; if (nd != 1)   begin miscompares++; $display("FAIL gap_done_count: got %0d expected 1", nd); end
        vectors++; if (tx != 3)   begin miscompares++; $display("FAIL gap_tx_count: got %0d expected 3", tx); end
        vectors++; if (det != 3)  begin miscompares++; $display("FAIL gap_detected: got %0d expected 3", det); end
    endtask

    task automatic test_back_to_back();
        int nv, nd, fa, da, det, tx;
        run_burst(3, 0, 1'b0, nv, nd, fa, da, det, tx);
        vectors++; if (nv != 12)  begin miscompares++; $display("FAIL b2b_valid_cycles: got %0d expected 12", nv); end
        vectors++; if (da != 13)  begin miscompares++; $display("FAIL b2b_done_cycle: got %0d expected 13", da); end
        vectors++; if (tx != 3)   begin miscompares++; $display("FAIL b2b_tx_count: got %0d expected 3", tx); end
        vectors++; if (det != 3)  begin miscompares++; $display("FAIL b2b_detected: got %0d expected 3", det); end
    endtask

    task automatic test_zero_rep();
        int nv, nd, fa, da, det, tx;
        run_burst(0, 5, 1'b0, nv, nd, fa, da, det, tx);
        vectors++; if (nv != 0)   begin miscompares++; $display("FAIL zero_valid_cycles: got %0d expected 0", nv); end
        vectors++; if (da != 1)   begin miscompares++; $display("FAIL zero_done_cycle: got %0d expected 1", da); end
        vectors++; if (nd != 1)   begin miscompares++; $display("FAIL zero_done_count: got %0d expected 1", nd); end
        vectors++; if (tx != 0)   begin miscompares++; $display("FAIL zero_tx_count: got %0d expected 0", tx); end
    endtask

    task automatic test_start_ignored();
        int nv, nd, fa, da, det, tx;
        run_burst(2, 1, 1'b1, nv, nd, fa, da, det, tx);
        vectors++; if (nv != 9)   begin miscompares++; $display("FAIL spam_valid_cycles: got %0d expected 9", nv); end
        vectors++; if (nd != 1)   begin miscompares++; $display("FAIL spam_done_count: got %0d expected 1", nd); end
        vectors++; if (da != 10)  begin miscompares++; $display("FAIL spam_done_cycle: got %0d expected 10", da); end
        vectors++; if (tx != 2)   begin miscompares++; $display("FAIL spam_tx_count: got %0d expected 2", tx); end
    endtask

    task automatic test_reset_mid_burst();
        int nv, nd, fa, da, det, tx;
        int seen;
        int cyc;
        @(posedge clk); #1;
        start = 1'b1; rep_cnt = 8'd3; gap = 4'd2;
        @(posedge clk); #1;
        start = 1'b0;
        seen = 0; cyc = 0;
        while (seen < 5 && cyc < 50) begin
            @(negedge clk);
            if (valid_out) seen++;
            cyc++;
        end
        vectors++;
        if (seen != 5) begin
            miscompares++;
            $display("FAIL abort_setup: saw %0d valid bits, required 5", seen);
        end
        #1 rst = 1'b1;
        #1;
        vectors++;
        if ({d_out, valid_out, busy, done} !== 4'b0000 || tx_count !== 8'd0) begin
            miscompares++;
            $display("FAIL abort_async: d/v/b/d=%b tx=%0d expected 0000 and 0",
                     {d_out, valid_out, busy, done}, tx_count);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            vectors++;
            if (done !== 1'b0 || valid_out !== 1'b0) begin
                miscompares++;
                $display("FAIL abort_quiet: done=%0b valid=%0b expected 0/0", done, valid_out);
            end
        end
        rst = 1'b0;
        run_burst(2, 1, 1'b0, nv, nd, fa, da, det, tx);
        vectors++; if (nv != 9)   begin miscompares++; $display("FAIL post_abort_valid: got %0d expected 9", nv); end
        vectors++; if (tx != 2)   begin miscompares++; $display("FAIL post_abort_tx: got %0d expected 2", tx); end
        vectors++; if (det != 2)  begin miscompares++; $display("FAIL post_abort_detected: got %0d expected 2", det); end
    endtask

    task automatic test_max();
        int nv, nd, fa, da, det, tx;
        run_burst(255, 15, 1'b0, nv, nd, fa, da, det, tx);
        vectors++; if (nv != 4830) begin miscompares++; $display("FAIL max_valid_cycles: got %0d expected 4830", nv); end
        vectors++; if (tx != 255)  begin miscompares++; $display("FAIL max_tx_count: got %0d expected 255", tx); end
        vectors++; if (nd != 1)    begin miscompares++; $display("FAIL max_done_count: got %0d expected 1", nd); end
        vectors++; if (da != 4831) begin miscompares++; $display("FAIL max_done_cycle: got %0d expected 4831", da); end
        vectors++; if (det != 255) begin miscompares++; $display("FAIL max_detected: got %0d expected 255", det); end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        start       = 1'b0;
        rep_cnt     = 8'd0;
        gap         = 4'd0;
        test_reset();
        test_gap();
        test_back_to_back();
        test_zero_rep();
        test_start_ignored();
        test_reset_mid_burst();
        test_max();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
